// File: rtl/mc_control.sv
// mc_control: multi-cycle instruction sequencer (Moore FSM).
// Optional feature: define MC_MEM_WAIT_EN to make FETCH/MEMRD/MEMWR stall
// until mem_ready; otherwise mem_ready is ignored and memory states take one cycle.
module mc_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_wr,
    output logic       iord,
    output logic       ir_wr,
    output logic       pc_wr,
    output logic       pc_wr_cond,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_sel,
    output logic       reg_wr,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_REXE    = 4'd6,
        S_RWB     = 4'd7,
        S_IEXE    = 4'd8,
        S_IWB     = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11,
        S_JAL     = 4'd12,
        S_ILLEGAL = 4'd13
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_ready;
    logic   w_ir_wr;
    logic   w_pc_wr;

`ifdef MC_MEM_WAIT_EN
    assign w_ready = mem_ready;
`else
    // Memory always completes in one cycle; keep the port referenced.
    logic w_unused_ready;
    assign w_unused_ready = mem_ready;
    assign w_ready        = 1'b1;
`endif

    // State register; reset forces FETCH without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    // Next-state logic, including opcode dispatch from DECODE.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = w_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    6'b000000:                         w_next = S_REXE;
                    6'b100011, 6'b100000, 6'b100100,
                    6'b101011, 6'b101000:              w_next = S_MEMADR;
                    6'b001001, 6'b001010, 6'b001011,
                    6'b001100, 6'b001101, 6'b001110,
                    6'b001111:                         w_next = S_IEXE;
                    6'b000001, 6'b000100, 6'b000101,
                    6'b000110, 6'b000111:              w_next = S_BRANCH;
                    6'b000010:                         w_next = S_JUMP;
                    6'b000011:                         w_next = S_JAL;
                    default:                           w_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR:  w_next = op[3] ? S_MEMWR : S_MEMRD;
            S_MEMRD:   w_next = w_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   w_next = w_ready ? S_FETCH : S_MEMWR;
            S_REXE:    w_next = S_RWB;
            S_IEXE:    w_next = S_IWB;
            S_ILLEGAL: w_next = S_ILLEGAL;
            default:   w_next = S_FETCH;   // single-cycle states and unused codes
        endcase
    end

    // Moore output decode; only the FETCH/MEMWR strobes look at mem_ready.
    always_comb begin
        mem_req    = 1'b0;
        mem_wr     = 1'b0;
        iord       = 1'b0;
        w_ir_wr    = 1'b0;
        w_pc_wr    = 1'b0;
        pc_wr_cond = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_sel    = 2'b00;
        reg_wr     = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                w_ir_wr   = w_ready;
                w_pc_wr   = w_ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                reg_wr     = 1'b1;
                mem_to_reg = 2'b01;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_req    = 1'b1;
                iord       = 1'b1;
                mem_wr     = 1'b1;
                instr_done = w_ready;
            end
            S_REXE: begin
                alu_src_a = 1'b1;
                alu_sel   = 2'b10;
            end
            S_RWB: begin
                reg_wr     = 1'b1;
                reg_dst    = 2'b01;
                instr_done = 1'b1;
            end
            S_IEXE: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_sel   = 2'b11;
            end
            S_IWB: begin
                reg_wr     = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_sel    = 2'b01;
                pc_wr_cond = 1'b1;
                pc_src     = 2'b01;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                w_pc_wr    = 1'b1;
                pc_src     = 2'b10;
                instr_done = 1'b1;
            end
            S_JAL: begin
                w_pc_wr    = 1'b1;
                pc_src     = 2'b10;
                reg_wr     = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                instr_done = 1'b1;
            end
            S_ILLEGAL: illegal = 1'b1;
            default: ;
        endcase
    end

    // Reset parks the FSM in FETCH; keep its fetch strobes quiet while held.
    assign ir_wr = w_ir_wr & rst_n;
    assign pc_wr = w_pc_wr & rst_n;
    assign state = r_state;

endmodule

// File: tb/tb_mc_control.sv
// Randomized bench for mc_control against an instruction-path reference model.
module tb_mc_control;

    localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4,
                   MEMWR = 5, REXE = 6, RWB = 7, IEXE = 8, IWB = 9,
                   BRANCH = 10, JUMP = 11, JAL = 12, ILLEGAL = 13;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = 6'd0;
    logic       mem_ready = 1'b1;
    logic       mem_req, mem_wr, iord, ir_wr, pc_wr, pc_wr_cond;
    logic [1:0] pc_src, alu_src_b, alu_sel, reg_dst, mem_to_reg;
    logic       alu_src_a, reg_wr, instr_done, illegal;
    logic [3:0] state;

    mc_control dut (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_wr(mem_wr), .iord(iord), .ir_wr(ir_wr),
        .pc_wr(pc_wr), .pc_wr_cond(pc_wr_cond), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_sel(alu_sel),
        .reg_wr(reg_wr), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .instr_done(instr_done), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Whether memory is considered complete this cycle.
    function automatic logic eff(input logic r);
`ifdef MC_MEM_WAIT_EN
        return r;
`else
        return r | 1'b1;
`endif
    endfunction

    // Expected output vector per state, straight from the per-state output table.
    function automatic logic [19:0] exp_outs(input int s, input logic rdy);
        logic mr, mw, io, irw, pcw, pcc, asa, rw, dn, il;
        logic [1:0] ps, asb, asl, rd, m2r;
        {mr, mw, io, irw, pcw, pcc, asa, rw, dn, il} = '0;
        {ps, asb, asl, rd, m2r} = '0;
        case (s)
            FETCH:   begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            DECODE:  asb = 2'b11;
            MEMADR:  begin asa = 1; asb = 2'b10; end
            MEMRD:   begin mr = 1; io = 1; end
            MEMWB:   begin rw = 1; m2r = 2'b01; dn = 1; end
            MEMWR:   begin mr = 1; io = 1; mw = 1; dn = rdy; end
            REXE:    begin asa = 1; asl = 2'b10; end
            RWB:     begin rw = 1; rd = 2'b01; dn = 1; end
            IEXE:    begin asa = 1; asb = 2'b10; asl = 2'b11; end
            IWB:     begin rw = 1; dn = 1; end
            BRANCH:  begin asa = 1; asl = 2'b01; pcc = 1; ps = 2'b01; dn = 1; end
            JUMP:    begin pcw = 1; ps = 2'b10; dn = 1; end
            JAL:     begin pcw = 1; ps = 2'b10; rw = 1; rd = 2'b10; m2r = 2'b10; dn = 1; end
            ILLEGAL: il = 1;
            default: ;
        endcase
        return {mr, mw, io, irw, pcw, pcc, ps, asa, asb, asl, rw, rd, m2r, dn, il};
    endfunction

    logic [19:0] w_outs;
    assign w_outs = {mem_req, mem_wr, iord, ir_wr, pc_wr, pc_wr_cond, pc_src,
                     alu_src_a, alu_src_b, alu_sel, reg_wr, reg_dst, mem_to_reg,
                     instr_done, illegal};

    // Reference model: the full state path of the current instruction.
    int         path[$];
    int         idx;
    logic [5:0] nxt_op;
    int         opi = 0;
    logic [5:0] dir_ops[6] = '{6'b001001, 6'b100011, 6'b101000,
                               6'b000011, 6'b000100, 6'b111111};
    logic [5:0] legal_ops[20] = '{6'h00, 6'h23, 6'h20, 6'h24, 6'h2b, 6'h28,
                                  6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f,
                                  6'h01, 6'h04, 6'h05, 6'h06, 6'h07, 6'h02, 6'h03};

    task automatic new_instr();
        logic [5:0] o;
        if (opi < 6) begin
            o = dir_ops[opi];
            opi++;
        end else if ($urandom_range(0, 9) != 0) begin
            o = legal_ops[$urandom_range(0, 19)];
        end else begin
            o = 6'($urandom_range(0, 63));
        end
        nxt_op = o;
        path = {};
        path.push_back(FETCH);
        path.push_back(DECODE);
        if (o == 6'b000000) begin
            path.push_back(REXE); path.push_back(RWB);
        end else if (o inside {6'b100011, 6'b100000, 6'b100100}) begin
            path.push_back(MEMADR); path.push_back(MEMRD); path.push_back(MEMWB);
        end else if (o inside {6'b101011, 6'b101000}) begin
            path.push_back(MEMADR); path.push_back(MEMWR);
        end else if (o >= 6'b001001 && o <= 6'b001111) begin
            path.push_back(IEXE); path.push_back(IWB);
        end else if (o inside {6'b000001, 6'b000100, 6'b000101, 6'b000110, 6'b000111}) begin
            path.push_back(BRANCH);
        end else if (o == 6'b000010) begin
            path.push_back(JUMP);
        end else if (o == 6'b000011) begin
            path.push_back(JAL);
        end else begin
            path.push_back(ILLEGAL);
        end
        idx = 0;
    endtask

    logic rdy_prev;
    int   ill_cnt = 0;
    bit   br_rst_done = 0;

    // Asynchronous reset between clock edges; everything must clear at once.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("rst_state", 32'(state), 32'(FETCH));
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_strobes", 32'({reg_wr, mem_wr, pc_wr, pc_wr_cond, ir_wr, instr_done}), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_state", 32'(state), 32'(FETCH));
        chk("rst_hold_strobes", 32'({reg_wr, mem_wr, pc_wr, pc_wr_cond, ir_wr}), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        new_instr();
        op       = nxt_op;
        rdy_prev = 1'b1;
        ill_cnt  = 0;
    endtask

    initial begin
        int exp_s;
        #2;
        chk("por_state", 32'(state), 32'(FETCH));
        chk("por_illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        new_instr();
        op       = nxt_op;
        rdy_prev = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            exp_s = path[idx];
            if (exp_s == ILLEGAL) begin
                // stuck until reset
            end else if ((exp_s == FETCH || exp_s == MEMRD || exp_s == MEMWR) && !eff(rdy_prev)) begin
                // memory stall
            end else begin
                idx++;
                if (idx == path.size()) new_instr();
            end
            #1;
            op        = nxt_op;
            mem_ready = ($urandom_range(0, 3) != 0);
            rdy_prev  = mem_ready;
            @(negedge clk);
            exp_s = path[idx];
            chk("state", 32'(state), 32'(exp_s));
            chk("outs", 32'(w_outs), 32'(exp_outs(exp_s, eff(mem_ready))));
            if (exp_s == ILLEGAL) ill_cnt++;
            else                  ill_cnt = 0;
            if ((exp_s == BRANCH && !br_rst_done) || ill_cnt >= 3 ||
                $urandom_range(0, 59) == 0) begin
                if (exp_s == BRANCH) br_rst_done = 1;
                do_reset();
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 The block SHALL have these ports: clk  in  1  rising-edge clock.
REQ-002 The block SHALL have these ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 The block SHALL have these ports: op  in  6  opcode from the instruction register.
REQ-004 The block SHALL have these ports: mem_ready  in  1  memory completion strobe.
REQ-005 The block SHALL have these ports: mem_req  out  1  memory access active.
REQ-006 The block SHALL have these ports: mem_wr  out  1  memory write.
REQ-007 The block SHALL have these ports: iord  out  1  address select, 0=PC, 1=ALU result.
REQ-008 The block SHALL have these ports: ir_wr  out  1  instruction register load.
REQ-009 The block SHALL have these ports: pc_wr  out  1  unconditional PC load.
REQ-010 The block SHALL have these ports: pc_wr_cond  out  1  PC load gated by the datapath branch-compare result.
REQ-011 The block SHALL have these ports: pc_src  out  2  PC source, 00=ALU, 01=branch target, 10=jump target.
REQ-012 The block SHALL have these ports: alu_src_a  out  1  ALU A source, 0=PC, 1=rs.
REQ-013 The block SHALL have these ports: alu_src_b  out  2  ALU B source, 00=rt, 01=const 4, 10=ext imm, 11=ext imm<<2.
REQ-014 The block SHALL have these ports: alu_sel  out  2  ALU mode, 00=add, 01=branch compare, 10=funct decode, 11=imm-op decode.
REQ-015 The block SHALL have these ports: reg_wr  out  1  register file write.
REQ-016 The block SHALL have these ports: reg_dst  out  2  destination, 00=rt, 01=rd, 10=r31.
REQ-017 The block SHALL have these ports: mem_to_reg  out  2  writeback source, 00=ALU, 01=memory data, 10=PC.
REQ-018 The block SHALL have these ports: instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
REQ-019 The block SHALL have these ports: illegal  out  1  sticky unsupported-opcode flag.
REQ-020 The block SHALL have these ports: state  out  4  current state, for debug.

Function
REQ-021 States SHALL be encoded as FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXE=6, RWB=7, IEXE=8, IWB=9, BRANCH=10, JUMP=11, JAL=12, ILLEGAL=13. Codes 14 and 15 SHALL go to FETCH on the next cycle.
REQ-022 FETCH SHALL drive mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_sel=00, and pc_src=00. ir_wr and pc_wr SHALL be 1 only in the cycle where mem_ready=1, and that cycle SHALL go to DECODE.
REQ-023 DECODE SHALL drive alu_src_a=0, alu_src_b=11, and alu_sel=00 to form the branch target. It SHALL then dispatch on op as follows:
- 000000 goes to REXE.
- 100011, 100000, 100100, 101011, and 101000 go to MEMADR.
- 001001 through 001111 go to IEXE.
- 000001, 000100, 000101, 000110, and 000111 go to BRANCH.
- 000010 goes to JUMP.
- 000011 goes to JAL.
- Any other opcode goes to ILLEGAL.
REQ-024 MEMADR SHALL drive alu_src_a=1, alu_src_b=10, and alu_sel=00. It SHALL go to MEMWR if op[3]=1, else to MEMRD.
REQ-025 MEMRD SHALL drive mem_req=1 and iord=1. It SHALL hold while mem_ready=0 and go to MEMWB when mem_ready=1.
REQ-026 MEMWR SHALL drive mem_req=1, iord=1, and mem_wr=1. It SHALL hold while mem_ready=0 and go to FETCH when mem_ready=1. instr_done SHALL be 1 in that mem_ready=1 cycle.
REQ-027 MEMWB SHALL drive reg_wr=1, reg_dst=00, and mem_to_reg=01, and SHALL pulse instr_done.
REQ-028 REXE SHALL drive alu_src_a=1, alu_src_b=00, and alu_sel=10.
REQ-029 RWB SHALL drive reg_wr=1, reg_dst=01, and mem_to_reg=00, and SHALL pulse instr_done.
REQ-030 IEXE SHALL drive alu_src_a=1, alu_src_b=10, and alu_sel=11.
REQ-031 IWB SHALL drive reg_wr=1, reg_dst=00, and mem_to_reg=00, and SHALL pulse instr_done.
REQ-032 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_sel=01, pc_wr_cond=1, and pc_src=01, and SHALL pulse instr_done.
REQ-033 JUMP SHALL drive pc_wr=1 and pc_src=10, and SHALL pulse instr_done.
REQ-034 JAL SHALL drive pc_wr=1, pc_src=10, reg_wr=1, reg_dst=10, and mem_to_reg=10, and SHALL pulse instr_done.
REQ-035 After each single-cycle state above (MEMWB, REXE, RWB, IEXE, IWB, BRANCH, JUMP, JAL), the next state SHALL be the obvious successor: REXE to RWB, IEXE to IWB, and all others to FETCH.
REQ-036 Latency with mem_ready held at 1 SHALL be:
- load: 5 cycles.
- store, R-type, immediate: 4 cycles.
- branch, j, jal: 3 cycles.
REQ-037 ILLEGAL SHALL set illegal=1 and hold in ILLEGAL with every write strobe at 0 until reset. No instr_done pulse SHALL be issued.
REQ-038 Any output not listed for a state SHALL be 0. All outputs SHALL be decoded from registered state only (Moore), except the ir_wr, pc_wr and instr_done qualifiers gated by mem_ready.

Reset
REQ-039 When rst_n=0, the state SHALL be FETCH and illegal SHALL be 0 immediately, without waiting for clk.
REQ-040 Asserting rst_n mid-instruction SHALL abandon the instruction, with no further reg_wr, mem_wr or pc_wr.
REQ-041 The first fetch SHALL begin on the first rising edge after rst_n deasserts.

Configuration
REQ-042 With MC_MEM_WAIT_EN defined, FETCH, MEMRD and MEMWR SHALL stall on mem_ready=0 as described above.
REQ-043 Without MC_MEM_WAIT_EN, mem_ready SHALL be ignored and treated as 1, so every memory state lasts exactly one cycle.

Verification
REQ-044 op=001001 (addiu), mem_ready=1: the state sequence SHALL be 0,1,8,9,0; reg_wr=1 only in state 9; instr_done SHALL pulse once.
REQ-045 op=100011 (lw), MC_MEM_WAIT_EN defined, mem_ready low for 2 cycles in MEMRD: the sequence SHALL be 0,1,2,3,3,3,4,0; mem_to_reg=01 in state 4.
REQ-046 op=101000 (sb), mem_ready=1: the sequence SHALL be 0,1,2,5,0; mem_wr=1 only in state 5; reg_wr SHALL never assert.
REQ-047 op=000011 (jal): in state 12, pc_wr=1, reg_dst=10 and mem_to_reg=10; the following state SHALL be 0.
REQ-048 op=111111: the state SHALL go 0,1,13 and remain 13 with illegal=1; asserting rst_n=0 SHALL return state to 0 and illegal to 0 asynchronously.
REQ-049 op=000100 (beq) with rst_n asserted during BRANCH: state SHALL be 0 immediately, and the pc_wr_cond pulse SHALL be cut short.
